// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the two-digit 7-segment scan controller:
// scan state encoding, the all-off pattern and the hex glyph table (active-low, gfedcba).
package seg7_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      BLANK1 = 2'd0,
      DIG0   = 2'd1,
      BLANK0 = 2'd2,
      DIG1   = 2'd3
   } scan_state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [6:0] SEG_CODE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to 7-segment glyph (active-low, gfedcba).
module hex_to_seg7
   import seg7_scan_ctrl_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = SEG_CODE[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Two-digit 7-segment scan controller: per-frame snapshot of val, blanking between digits,
// optional leading-zero suppression, registered Moore outputs.
//
//   state  | meaning
//   BLANK1 | all off after the high digit (also the reset state)
//   DIG0   | low nibble lit on an0; entered on the snapshot edge
//   BLANK0 | all off between low and high digit
//   DIG1   | high nibble lit on an1 (or suppressed as a leading zero)
module seg7_scan_ctrl
   import seg7_scan_ctrl_pkg::*;
#(
   parameter int REFRESH_DIV = 4,
   parameter int BLANK_CYC   = 1,
   parameter int SEG_ACT_LOW = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] val,
   input  logic       lz_blank,
   output logic [6:0] swg,
   output logic       an0,
   output logic       an1,
   output logic       frame
);

   // With BLANK_CYC=0 the blank states are bypassed; only the post-reset BLANK1 is visited, for one cycle.
   localparam int BLANK_LEN = (BLANK_CYC == 0) ? 1 : BLANK_CYC;
   localparam int CNT_MAX   = (REFRESH_DIV > BLANK_LEN) ? REFRESH_DIV : BLANK_LEN;
   localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] DIG_LAST   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_LEN - 1);
   localparam logic INV = (SEG_ACT_LOW == 0);

   scan_state_t   state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [7:0]    snap, snap_nxt;
   logic          last, load;
   logic [3:0]    nib;
   logic [6:0]    seg_raw;
   logic          an0_l, an1_l;
   logic [6:0]    swg_l;

   always_comb begin
      state_nxt = state;
      snap_nxt  = snap;
      if ((state == DIG0) || (state == DIG1)) last = (cnt == DIG_LAST);
      else                                    last = (cnt == BLANK_LAST);
      if (last) begin
         case (state)
            BLANK1:  state_nxt = DIG0;
            DIG0:    state_nxt = (BLANK_CYC == 0) ? DIG1 : BLANK0;
            BLANK0:  state_nxt = DIG1;
            DIG1:    state_nxt = (BLANK_CYC == 0) ? DIG0 : BLANK1;
            default: state_nxt = BLANK1;
         endcase
      end
      cnt_nxt = last ? '0 : cnt + 1'b1;
      load    = (state_nxt == DIG0) && (state != DIG0);
      if (load) snap_nxt = val;
   end

   assign nib = (state_nxt == DIG1) ? snap_nxt[7:4] : snap_nxt[3:0];

   hex_to_seg7 u_hex (
      .hex (nib),
      .seg (seg_raw)
   );

   // Output decode works on the next state so pins change on the same edge as the state register.
   always_comb begin
      an0_l = 1'b1;
      an1_l = 1'b1;
      swg_l = SEG_OFF;
      case (state_nxt)
         DIG0: begin
            an0_l = 1'b0;
            swg_l = seg_raw;
         end
         DIG1: begin
            if (!(lz_blank && (snap_nxt[7:4] == 4'h0))) begin
               an1_l = 1'b0;
               swg_l = seg_raw;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BLANK1;
         cnt   <= '0;
         snap  <= 8'h00;
         frame <= 1'b0;
         an0   <= 1'b1 ^ INV;
         an1   <= 1'b1 ^ INV;
         swg   <= SEG_OFF ^ {7{INV}};
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         snap  <= snap_nxt;
         frame <= load;
         an0   <= an0_l ^ INV;
         an1   <= an1_l ^ INV;
         swg   <= swg_l ^ {7{INV}};
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: default build plus a no-blank, active-high build.
module tb_seg7_scan_ctrl;

   localparam logic [6:0] SEG_TBL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef struct packed {
      logic       frame;
      logic       an0;
      logic       an1;
      logic [6:0] swg;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] val;
   logic       lz_blank;
   logic [6:0] swg;
   logic       an0, an1, frame;
   logic [7:0] val2;
   logic       lz2;
   logic [6:0] swg2;
   logic       an0_2, an1_2, frame2;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   seg7_scan_ctrl u_dut (
      .clk      (clk),
      .rst      (rst),
      .val      (val),
      .lz_blank (lz_blank),
      .swg      (swg),
      .an0      (an0),
      .an1      (an1),
      .frame    (frame)
   );

   seg7_scan_ctrl #(.REFRESH_DIV(2), .BLANK_CYC(0), .SEG_ACT_LOW(0)) u_dut2 (
      .clk      (clk),
      .rst      (rst),
      .val      (val2),
      .lz_blank (lz2),
      .swg      (swg2),
      .an0      (an0_2),
      .an1      (an1_2),
      .frame    (frame2)
   );

   // One full default frame (4 lit, 1 blank, 4 lit, 1 blank); optional val change at cycle chg_at.
   task automatic run_frame(input logic [7:0] v, input logic lz, input int chg_at,
                            input logic [7:0] chg_v, input string tag);
      exp_t e, got;
      bit   hi_off;
      val      = v;
      lz_blank = lz;
      hi_off   = lz && (v[7:4] == 4'h0);
      for (int c = 0; c < 10; c++) begin
         if (c < 4)                  e = '{frame: (c == 0), an0: 1'b0, an1: 1'b1, swg: SEG_TBL[v[3:0]]};
         else if (c == 4 || c == 9)  e = '{frame: 1'b0, an0: 1'b1, an1: 1'b1, swg: 7'h7F};
         else if (hi_off)            e = '{frame: 1'b0, an0: 1'b1, an1: 1'b1, swg: 7'h7F};
         else                        e = '{frame: 1'b0, an0: 1'b1, an1: 1'b0, swg: SEG_TBL[v[7:4]]};
         exp_q.push_back(e);
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s val=%h cyc %0d: scoreboard empty", tag, v, c);
         end else begin
            e   = exp_q.pop_front();
            got = '{frame: frame, an0: an0, an1: an1, swg: swg};
            if (got !== e) begin
               n_fail++;
               $display("FAIL %s val=%h cyc %0d: got frame=%b an0=%b an1=%b swg=%h, expected frame=%b an0=%b an1=%b swg=%h",
                        tag, v, c, got.frame, got.an0, got.an1, got.swg, e.frame, e.an0, e.an1, e.swg);
            end
         end
         if (c == chg_at) val = chg_v;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; val = 8'h00; lz_blank = 1'b0; val2 = 8'h00; lz2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({frame, an0, an1, swg} !== {1'b0, 1'b1, 1'b1, 7'h7F}) begin
         n_fail++;
         $display("FAIL reset_idle: got frame=%b an0=%b an1=%b swg=%h, expected 0 1 1 7f", frame, an0, an1, swg);
      end
      n_tests++;
      if ({frame2, an0_2, an1_2, swg2} !== {1'b0, 1'b0, 1'b0, 7'h00}) begin
         n_fail++;
         $display("FAIL reset_idle_acthigh: got frame=%b an0=%b an1=%b swg=%h, expected 0 0 0 00", frame2, an0_2, an1_2, swg2);
      end
      @(negedge clk);
      rst = 1'b0;
      run_frame(8'h00, 1'b0, -1, 8'h00, "first_frame");
      run_frame(8'h00, 1'b0, -1, 8'h00, "frame_repeat");
   endtask

   task automatic test_snapshot();
      run_frame(8'h3A, 1'b0, -1, 8'h00, "snap_3a");
      run_frame(8'h3A, 1'b0, 6,  8'h5C, "snap_change_dig1");
      run_frame(8'h5C, 1'b0, 1,  8'hE7, "snap_change_dig0");
      run_frame(8'hE7, 1'b0, -1, 8'h00, "snap_e7");
   endtask

   task automatic test_lz_blank();
      for (int v = 0; v < 16; v++) run_frame(8'(v), 1'b1, -1, 8'h00, "lz_suppress");
      run_frame(8'h10, 1'b1, -1, 8'h00, "lz_nonzero");
      run_frame(8'h00, 1'b0, -1, 8'h00, "lz_off_zero");
   endtask

   task automatic test_async_reset();
      val = 8'h77; lz_blank = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if ({frame, an0, an1, swg} !== {1'b1, 1'b0, 1'b1, 7'h78}) begin
         n_fail++;
         $display("FAIL pre_reset_dig0: got frame=%b an0=%b an1=%b swg=%h, expected 1 0 1 78", frame, an0, an1, swg);
      end
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if ({frame, an0, an1, swg} !== {1'b0, 1'b1, 1'b1, 7'h7F}) begin
         n_fail++;
         $display("FAIL async_reset: got frame=%b an0=%b an1=%b swg=%h, expected 0 1 1 7f", frame, an0, an1, swg);
      end
      #29;
      rst = 1'b0;
      run_frame(8'h77, 1'b0, -1, 8'h00, "after_async_reset");
   endtask

   task automatic test_sweep();
      for (int v = 0; v < 256; v++) run_frame(8'(v), 1'b0, -1, 8'h00, "sweep");
   endtask

   // Active-high, no-blank build: four-cycle frame, random val and live lz each cycle.
   task automatic test_no_blank();
      exp_t       e, got;
      logic [7:0] snap_m;
      int         ph;
      snap_m = 8'h00;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         val2 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
         lz2  = 1'($urandom_range(0, 1));
         ph   = k % 4;
         if (ph == 0) snap_m = val2;
         if (ph < 2)                                e = '{frame: (ph == 0), an0: 1'b1, an1: 1'b0, swg: ~SEG_TBL[snap_m[3:0]]};
         else if (lz2 && (snap_m[7:4] == 4'h0))     e = '{frame: 1'b0, an0: 1'b0, an1: 1'b0, swg: 7'h00};
         else                                       e = '{frame: 1'b0, an0: 1'b0, an1: 1'b1, swg: ~SEG_TBL[snap_m[7:4]]};
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         n_tests++;
         e   = exp_q.pop_front();
         got = '{frame: frame2, an0: an0_2, an1: an1_2, swg: swg2};
         if (got !== e) begin
            n_fail++;
            $display("FAIL no_blank cyc %0d: got frame=%b an0=%b an1=%b swg=%h, expected frame=%b an0=%b an1=%b swg=%h",
                     k, got.frame, got.an0, got.an1, got.swg, e.frame, e.an0, e.an1, e.swg);
         end
         n_tests++;
         if (an0_2 && an1_2) begin
            n_fail++;
            $display("FAIL both_anodes cyc %0d: got an0=%b an1=%b, expected not both active", k, an0_2, an1_2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_snapshot();
      test_lz_blank();
      test_async_reset();
      test_sweep();
      test_no_blank();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish by 1 ms, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
